// File: rtl/tiny_soc_timer_irq.sv
// Memory-mapped 64-bit cycle counter, reloadable countdown timer and masked IRQ source for picorv32.
// Optional TOHOST stop/exit-code register is built when TINY_SOC_TOHOST_EN is defined.
module tiny_soc_timer_irq #(
  parameter logic [31:0] BaseAddr     = 32'h2000_0000,
  parameter int unsigned TimerIrqLine = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  strb_i,
  output logic        gnt_o,
  output logic [31:0] rdata_o,
  output logic [31:0] irq_o,
  input  logic [31:0] eoi_i,
  output logic        stop_o,
  output logic [30:0] exit_code_o
);

  // state   | meaning
  // ST_IDLE | timer halted, TIMER holds its value
  // ST_RUN  | TIMER decrements each cycle, expiry at zero
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [31:0] TimerBit = 32'd1 << TimerIrqLine;

  state_t      r_state, w_state_d;
  logic [63:0] r_mtime;
  logic [31:0] r_mtime_hi_sh;
  logic [31:0] r_timer, r_reload, r_pend, r_mask, r_eoi_q, r_rdata;
  logic [1:0]  r_ctrl;

  logic        w_hit, w_wr, w_rd, w_expire;
  logic [3:0]  w_off;
  logic [31:0] w_bmask, w_wmasked, w_timer_d, w_pend_d, w_set, w_w1c, w_eoi_rise, w_rdata;
  logic [1:0]  w_ctrl_d;
  logic        w_wr_timer, w_wr_reload, w_wr_ctrl, w_wr_pend, w_wr_mask, w_wr_force;
  logic        w_unused_addr;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = wd[b*8 +: 8];
    end
    return res;
  endfunction

  assign w_hit         = req_i && (addr_i[31:6] == BaseAddr[31:6]);
  assign w_off         = addr_i[5:2];
  assign w_wr          = w_hit && we_i;
  assign w_rd          = w_hit && !we_i;
  assign w_unused_addr = ^addr_i[1:0];

  assign w_bmask   = {{8{strb_i[3]}}, {8{strb_i[2]}}, {8{strb_i[1]}}, {8{strb_i[0]}}};
  assign w_wmasked = wdata_i & w_bmask;

  assign w_wr_timer  = w_wr && (w_off == 4'd2);
  assign w_wr_reload = w_wr && (w_off == 4'd3);
  assign w_wr_ctrl   = w_wr && (w_off == 4'd4);
  assign w_wr_pend   = w_wr && (w_off == 4'd5);
  assign w_wr_mask   = w_wr && (w_off == 4'd6);
  assign w_wr_force  = w_wr && (w_off == 4'd7);

  assign gnt_o   = 1'b1;
  assign rdata_o = r_rdata;
  assign irq_o   = r_pend & r_mask;

  // Software writes to TIMER/CTRL take precedence over the hardware update in the same cycle.
  always_comb begin
    w_timer_d = r_timer;
    w_ctrl_d  = r_ctrl;
    w_expire  = 1'b0;
    if (r_state == ST_RUN) begin
      if (r_timer == 32'd0) begin
        w_expire = 1'b1;
        if (r_ctrl[1]) w_timer_d = r_reload;
        else           w_ctrl_d[0] = 1'b0;
      end else begin
        w_timer_d = r_timer - 32'd1;
      end
    end
    if (w_wr_timer) w_timer_d = f_merge(r_timer, wdata_i, strb_i);
    if (w_wr_ctrl && strb_i[0]) w_ctrl_d = wdata_i[1:0];
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (w_ctrl_d[0])  w_state_d = ST_RUN;
      ST_RUN:  if (!w_ctrl_d[0]) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_d;
  end

  // Set beats W1C, W1C beats end-of-interrupt clear.
  assign w_set      = (w_wr_force ? w_wmasked : 32'd0) | (w_expire ? TimerBit : 32'd0);
  assign w_w1c      = w_wr_pend ? w_wmasked : 32'd0;
  assign w_eoi_rise = eoi_i & ~r_eoi_q;
  assign w_pend_d   = (r_pend & ~w_w1c & ~w_eoi_rise) | w_set;

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (w_off)
        4'd0:    w_rdata = r_mtime[31:0];
        4'd1:    w_rdata = r_mtime_hi_sh;
        4'd2:    w_rdata = r_timer;
        4'd3:    w_rdata = r_reload;
        4'd4:    w_rdata = {30'd0, r_ctrl};
        4'd5:    w_rdata = r_pend;
        4'd6:    w_rdata = r_mask;
        default: w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mtime       <= '0;
      r_mtime_hi_sh <= '0;
      r_timer       <= '0;
      r_reload      <= '0;
      r_ctrl        <= '0;
      r_pend        <= '0;
      r_mask        <= '0;
      r_eoi_q       <= '0;
      r_rdata       <= '0;
    end else begin
      r_mtime <= r_mtime + 64'd1;
      r_timer <= w_timer_d;
      r_ctrl  <= w_ctrl_d;
      r_pend  <= w_pend_d;
      r_eoi_q <= eoi_i;
      r_rdata <= w_rdata;
      if (w_wr_reload) r_reload <= f_merge(r_reload, wdata_i, strb_i);
      if (w_wr_mask)   r_mask   <= f_merge(r_mask, wdata_i, strb_i);
      // Latching HI on a LO read keeps a LO-then-HI pair coherent across a carry.
      if (w_rd && (w_off == 4'd0)) r_mtime_hi_sh <= r_mtime[63:32];
    end
  end

`ifdef TINY_SOC_TOHOST_EN
  logic        r_stop;
  logic [30:0] r_exit_code;
  logic        w_wr_tohost;
  logic [31:0] w_tohost_m;
  logic        w_unused_tohost;

  assign w_wr_tohost     = w_wr && (w_off == 4'd8);
  assign w_tohost_m      = f_merge({r_exit_code, 1'b0}, wdata_i, strb_i);
  assign w_unused_tohost = w_tohost_m[0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stop      <= 1'b0;
      r_exit_code <= '0;
    end else if (w_wr_tohost && strb_i[0] && wdata_i[0] && !r_stop) begin
      r_stop      <= 1'b1;
      r_exit_code <= w_tohost_m[31:1];
    end
  end

  assign stop_o      = r_stop;
  assign exit_code_o = r_exit_code;
`else
  assign stop_o      = 1'b0;
  assign exit_code_o = '0;
`endif

endmodule

// File: tb/tb_tiny_soc_timer_irq.sv
// Self-checking bench for tiny_soc_timer_irq: register vector table, read scoreboard, timer/IRQ sequences.
module tb_tiny_soc_timer_irq;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  strb_i;
  logic        gnt_o;
  logic [31:0] rdata_o, irq_o, eoi_i;
  logic        stop_o;
  logic [30:0] exit_code_o;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;
  bit rd_prev = 1'b0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          we;
    logic [3:0]  off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  tiny_soc_timer_irq #(.BaseAddr(BASE), .TimerIrqLine(7)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .gnt_o(gnt_o), .rdata_o(rdata_o), .irq_o(irq_o),
    .eoi_i(eoi_i), .stop_o(stop_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write_addr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; strb_i = s;
    tick();
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    do_write_addr(BASE | {26'd0, off, 2'b00}, d, s);
  endtask

  task automatic do_read_addr(input logic [31:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; strb_i = 4'h0;
    tick();
    req_i = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] off, input logic [31:0] exp, input string name);
    do_read_addr(BASE | {26'd0, off, 2'b00}, exp, name);
  endtask

  function automatic vec_t mk(input bit we, input logic [3:0] off, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] exp, input string name);
    vec_t v;
    v.we = we; v.off = off; v.data = d; v.strb = s; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Read data appears the cycle after a granted read; otherwise it must be 0.
  always @(posedge clk_i) rd_prev <= rst_ni && req_i && !we_i;

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rd_prev) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: rdata 0x%0h with no expectation queued", rdata_o);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk(e.name, rdata_o, e.exp);
        end
      end else begin
        chk("rdata_idle_zero", rdata_o, 0);
      end
    end
  end

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; strb_i = '0; eoi_i = '0;

    vecs.push_back(mk(1, 4'd6, 32'h0000_0000, 4'hF, 0, "mask_clr"));
    vecs.push_back(mk(1, 4'd6, 32'hFFFF_FFFF, 4'b0010, 0, "mask_strb"));
    vecs.push_back(mk(0, 4'd6, 0, 0, 32'h0000_FF00, "mask_strb_rd"));
    vecs.push_back(mk(1, 4'd3, 32'h1234_5678, 4'hF, 0, "reload_wr"));
    vecs.push_back(mk(1, 4'd3, 32'hAABB_CCDD, 4'b1001, 0, "reload_strb"));
    vecs.push_back(mk(0, 4'd3, 0, 0, 32'hAA34_56DD, "reload_strb_rd"));
    vecs.push_back(mk(1, 4'd4, 32'h0000_0002, 4'hF, 0, "ctrl_auto_only"));
    vecs.push_back(mk(0, 4'd4, 0, 0, 32'h0000_0002, "ctrl_rd"));
    vecs.push_back(mk(1, 4'd4, 32'h0000_0000, 4'hF, 0, "ctrl_clr"));
    vecs.push_back(mk(0, 4'd7, 0, 0, 32'h0, "force_reads_zero"));
    vecs.push_back(mk(1, 4'd12, 32'hDEAD_BEEF, 4'hF, 0, "unmapped_wr"));
    vecs.push_back(mk(0, 4'd12, 0, 0, 32'h0, "unmapped_rd"));
    vecs.push_back(mk(0, 4'd15, 0, 0, 32'h0, "unmapped_rd15"));
    vecs.push_back(mk(1, 4'd1, 32'hFFFF_FFFF, 4'hF, 0, "mtime_hi_wr_ignored"));
    vecs.push_back(mk(0, 4'd5, 0, 0, 32'h0, "pending_zero"));
    vecs.push_back(mk(1, 4'd2, 32'h0000_ABCD, 4'hF, 0, "timer_wr"));
    vecs.push_back(mk(1, 4'd2, 32'h0000_0012, 4'b0001, 0, "timer_strb"));
    vecs.push_back(mk(0, 4'd2, 0, 0, 32'h0000_AB12, "timer_idle_hold"));

    // Reset: outputs must be 0 while reset is held.
    repeat (3) tick();
    chk("rst_rdata", rdata_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_stop", stop_o, 0);
    chk("rst_exit", exit_code_o, 0);
    chk("gnt_always", gnt_o, 1);

    // MTIME is 0 in the first cycle with rst_ni high; after 9 edges it reads 9.
    rst_ni = 1'b1;
    mon_en = 1'b1;
    repeat (9) tick();
    do_read(4'd0, 32'd9, "mtime_lo");
    do_read(4'd1, 32'd0, "mtime_hi_shadow");

    foreach (vecs[i]) begin
      if (vecs[i].we) do_write(vecs[i].off, vecs[i].data, vecs[i].strb);
      else            do_read(vecs[i].off, vecs[i].exp, vecs[i].name);
    end

    // Requests outside the 64-byte window are ignored and read 0.
    do_write_addr(BASE + 32'h58, 32'hFFFF_FFFF, 4'hF);
    do_read_addr(BASE + 32'h40, 32'h0, "nonhit_rd");
    do_read(4'd6, 32'h0000_FF00, "nonhit_wr_ignored");

    // Auto-reload: CTRL written in cycle W, expiry in W+6, irq in W+7, period 6.
    do_write(4'd3, 32'd5, 4'hF);
    do_write(4'd2, 32'd5, 4'hF);
    do_write(4'd6, 32'h80, 4'hF);
    do_write(4'd4, 32'd3, 4'hF);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("auto_irq_low_c%0d", i), irq_o[7], 0);
      tick();
    end
    chk("auto_irq_rise", irq_o[7], 1);
    do_write(4'd5, 32'h80, 4'hF);
    for (int i = 8; i <= 12; i++) begin
      chk($sformatf("w1c_irq_low_c%0d", i), irq_o[7], 0);
      tick();
    end
    chk("auto_rearm", irq_o[7], 1);
    do_read(4'd2, 32'd5, "timer_read_after_reload");
    do_write(4'd5, 32'h80, 4'hF);
    for (int i = 15; i <= 17; i++) begin
      chk($sformatf("rearm_irq_low_c%0d", i), irq_o[7], 0);
      tick();
    end
    do_write(4'd5, 32'h80, 4'hF);
    chk("expiry_beats_w1c", irq_o[7], 1);
    do_write(4'd4, 32'd0, 4'hF);
    do_write(4'd5, 32'hFFFF_FFFF, 4'hF);
    do_read(4'd4, 32'd0, "ctrl_stopped");
    do_read(4'd5, 32'd0, "pending_cleared");

    // One-shot: TIMER=3, expiry 4 cycles after EN, then EN clears and TIMER stays 0.
    do_write(4'd2, 32'd3, 4'hF);
    do_write(4'd4, 32'd1, 4'hF);
    repeat (6) tick();
    chk("oneshot_irq", irq_o, 32'h80);
    do_read(4'd5, 32'h80, "oneshot_pending");
    do_read(4'd4, 32'd0, "oneshot_ctrl_cleared");
    do_read(4'd2, 32'd0, "oneshot_timer_zero");
    do_write(4'd5, 32'h80, 4'hF);
    repeat (10) tick();
    do_read(4'd5, 32'd0, "oneshot_no_rearm");
    do_read(4'd2, 32'd0, "oneshot_timer_held");

    // FORCE and end-of-interrupt edge clearing.
    do_write(4'd6, 32'h1, 4'hF);
    do_write(4'd7, 32'h11, 4'hF);
    chk("force_irq", irq_o, 32'h1);
    do_read(4'd5, 32'h11, "force_pending");
    eoi_i = 32'h1;
    tick();
    do_read(4'd5, 32'h10, "eoi_rise_clear");
    do_write(4'd7, 32'h1, 4'hF);
    tick();
    do_read(4'd5, 32'h11, "eoi_level_no_clear");
    eoi_i = 32'h0;
    tick();
    eoi_i = 32'h1;
    tick();
    do_read(4'd5, 32'h10, "eoi_second_rise");
    chk("eoi_irq_low", irq_o, 32'h0);
    eoi_i = 32'h0;

    do_write(4'd8, 32'h7, 4'hF);
`ifdef TINY_SOC_TOHOST_EN
    chk("tohost_stop", stop_o, 1);
    chk("tohost_exit", exit_code_o, 3);
    do_write(4'd8, 32'h11, 4'hF);
    chk("tohost_sticky", exit_code_o, 3);
`else
    chk("tohost_off_stop", stop_o, 0);
    chk("tohost_off_exit", exit_code_o, 0);
`endif
    do_read(4'd8, 32'h0, "tohost_reads_zero");

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
